sram_arbiter: RTL

Two-requester controller for the shared 32-bit external SRAM. It arbitrates round-robin between port A (CPU IO bus) and port B (a secondary master such as DMA or a debug loader). It sequences read, full-word write and read-modify-write cycles with programmable latency, and returns a one-cycle ready pulse to the granted port. It sits between the CPU memory decode and the SRAM pins; the top level owns the tri-state pad.

---
 rtl/sram_arbiter_pkg.sv | 27 ++
 rtl/sram_arbiter_rr.sv | 28 ++
 rtl/sram_arbiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the two-port SRAM arbiter: FSM encoding, default
// latencies and the read-modify-write byte merge.
package sram_arbiter_pkg;

    localparam int DEF_RD_LATENCY = 1;
    localparam int DEF_WR_LATENCY = 1;
    localparam int LCOUNT_W       = 3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_READ     = 3'd1,
        ST_RMW_READ = 3'd2,
        ST_WRITE    = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    function automatic logic [31:0] merge_bytes(input logic [31:0] wdata,
                                                input logic [31:0] rdata,
                                                input logic [3:0]  be);
        logic [31:0] result;
        for (int i = 0; i < 4; i++) begin
            result[8*i +: 8] = be[i] ? wdata[8*i +: 8] : rdata[8*i +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/sram_arbiter_rr.sv
// Two-way round-robin grant; holds the last-grant flop, which resets to B
// so that A wins the first tie.
module rr_arbiter2 (
    input  logic i_clk,
    input  logic i_rst_b,
    input  logic i_req_a,
    input  logic i_req_b,
    input  logic i_update,
    output logic o_gnt_a,
    output logic o_gnt_b
);

    logic r_last_b;

    always_comb begin
        o_gnt_a = i_req_a & (~i_req_b | r_last_b);
        o_gnt_b = i_req_b & (~i_req_a | ~r_last_b);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_b) begin
            r_last_b <= 1'b1;
        end else if (i_update && (o_gnt_a || o_gnt_b)) begin
            r_last_b <= o_gnt_b;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin controller for the shared 32-bit SRAM: read, full write and
// read-modify-write cycles with programmable wait states. All outputs registered.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int RD_LATENCY = DEF_RD_LATENCY,
    parameter int WR_LATENCY = DEF_WR_LATENCY,
    parameter int ADDR_W     = 19
) (
    input  logic              i_clk,
    input  logic              i_rst_b,
    input  logic              i_a_rd,
    input  logic              i_a_wr,
    input  logic [ADDR_W-1:0] i_a_addr,
    input  logic [3:0]        i_a_be,
    input  logic [31:0]       i_a_wdata,
    output logic [31:0]       o_a_rdata,
    output logic              o_a_rdy,
    input  logic              i_b_rd,
    input  logic              i_b_wr,
    input  logic [ADDR_W-1:0] i_b_addr,
    input  logic [3:0]        i_b_be,
    input  logic [31:0]       i_b_wdata,
    output logic [31:0]       o_b_rdata,
    output logic              o_b_rdy,
    output logic              o_ram_cs_b,
    output logic              o_ram_oe_b,
    output logic              o_ram_we_b,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [31:0]       o_ram_dout,
    output logic              o_ram_dout_oe,
    input  logic [31:0]       i_ram_din
);

    localparam logic [LCOUNT_W-1:0] RD_LC = LCOUNT_W'(RD_LATENCY);
    localparam logic [LCOUNT_W-1:0] WR_LC = LCOUNT_W'(WR_LATENCY);

    state_t              r_state, w_state_n;
    logic [LCOUNT_W-1:0] r_lcount, w_lcount_n;
    logic                r_sel_b, w_sel_b_n;
    logic [3:0]          r_be, w_be_n;
    logic [31:0]         r_wdata, w_wdata_n;
    logic                r_cs_b, w_cs_b_n;
    logic                r_oe_b, w_oe_b_n;
    logic                r_we_b, w_we_b_n;
    logic                r_dout_oe, w_dout_oe_n;
    logic [ADDR_W-1:0]   r_addr, w_addr_n;
    logic [31:0]         r_dout, w_dout_n;
    logic [31:0]         r_a_rdata, w_a_rdata_n;
    logic [31:0]         r_b_rdata, w_b_rdata_n;
    logic                r_a_rdy, w_a_rdy_n;
    logic                r_b_rdy, w_b_rdy_n;

    logic                w_gnt_a, w_gnt_b;
    logic                w_sel_rd;
    logic [3:0]          w_sel_be;
    logic [31:0]         w_sel_wdata;
    logic [ADDR_W-1:0]   w_sel_addr;

    rr_arbiter2 u_rr (
        .i_clk    (i_clk),
        .i_rst_b  (i_rst_b),
        .i_req_a  (i_a_rd | i_a_wr),
        .i_req_b  (i_b_rd | i_b_wr),
        .i_update (r_state == ST_IDLE),
        .o_gnt_a  (w_gnt_a),
        .o_gnt_b  (w_gnt_b)
    );

    // Rd wins over wr on the same port; wr is implied when rd is low.
    always_comb begin
        w_sel_rd    = w_gnt_b ? i_b_rd    : i_a_rd;
        w_sel_be    = w_gnt_b ? i_b_be    : i_a_be;
        w_sel_wdata = w_gnt_b ? i_b_wdata : i_a_wdata;
        w_sel_addr  = w_gnt_b ? i_b_addr  : i_a_addr;
    end

    always_comb begin
        w_state_n   = r_state;
        w_lcount_n  = r_lcount;
        w_sel_b_n   = r_sel_b;
        w_be_n      = r_be;
        w_wdata_n   = r_wdata;
        w_cs_b_n    = r_cs_b;
        w_oe_b_n    = r_oe_b;
        w_we_b_n    = r_we_b;
        w_dout_oe_n = r_dout_oe;
        w_addr_n    = r_addr;
        w_dout_n    = r_dout;
        w_a_rdata_n = r_a_rdata;
        w_b_rdata_n = r_b_rdata;
        w_a_rdy_n   = 1'b0;
        w_b_rdy_n   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_gnt_a || w_gnt_b) begin
                    w_sel_b_n = w_gnt_b;
                    w_be_n    = w_sel_be;
                    w_wdata_n = w_sel_wdata;
                    w_addr_n  = w_sel_addr;
                    if (w_sel_rd || (w_sel_be != 4'hF && w_sel_be != 4'h0)) begin
                        w_cs_b_n   = 1'b0;
                        w_oe_b_n   = 1'b0;
                        w_we_b_n   = 1'b1;
                        w_lcount_n = RD_LC;
                        w_state_n  = w_sel_rd ? ST_READ : ST_RMW_READ;
                    end else if (w_sel_be == 4'hF) begin
                        w_cs_b_n    = 1'b0;
                        w_oe_b_n    = 1'b1;
                        w_we_b_n    = 1'b0;
                        w_dout_n    = w_sel_wdata;
                        w_dout_oe_n = 1'b1;
                        w_lcount_n  = WR_LC;
                        w_state_n   = ST_WRITE;
                    end else begin
                        w_a_rdy_n = w_gnt_a;
                        w_b_rdy_n = w_gnt_b;
                        w_state_n = ST_DONE;
                    end
                end
            end
            ST_READ: begin
                if (r_lcount == '0) begin
                    if (r_sel_b) w_b_rdata_n = i_ram_din;
                    else         w_a_rdata_n = i_ram_din;
                    w_cs_b_n  = 1'b1;
                    w_oe_b_n  = 1'b1;
                    w_we_b_n  = 1'b1;
                    w_a_rdy_n = ~r_sel_b;
                    w_b_rdy_n = r_sel_b;
                    w_state_n = ST_DONE;
                end else begin
                    w_lcount_n = r_lcount - 1'b1;
                end
            end
            ST_RMW_READ: begin
                if (r_lcount == '0) begin
                    w_dout_n    = merge_bytes(r_wdata, i_ram_din, r_be);
                    w_oe_b_n    = 1'b1;
                    w_we_b_n    = 1'b0;
                    w_dout_oe_n = 1'b1;
                    w_lcount_n  = WR_LC;
                    w_state_n   = ST_WRITE;
                end else begin
                    w_lcount_n = r_lcount - 1'b1;
                end
            end
            ST_WRITE: begin
                if (r_lcount == '0) begin
                    w_cs_b_n    = 1'b1;
                    w_oe_b_n    = 1'b1;
                    w_we_b_n    = 1'b1;
                    w_dout_oe_n = 1'b0;
                    w_a_rdy_n   = ~r_sel_b;
                    w_b_rdy_n   = r_sel_b;
                    w_state_n   = ST_DONE;
                end else begin
                    w_lcount_n = r_lcount - 1'b1;
                end
            end
            ST_DONE:  w_state_n = ST_IDLE;
            default:  w_state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_b) begin
            r_state   <= ST_IDLE;
            r_lcount  <= '0;
            r_sel_b   <= 1'b0;
            r_be      <= '0;
            r_wdata   <= '0;
            r_cs_b    <= 1'b1;
            r_oe_b    <= 1'b1;
            r_we_b    <= 1'b1;
            r_dout_oe <= 1'b0;
            r_addr    <= '0;
            r_dout    <= '0;
            r_a_rdata <= '0;
            r_b_rdata <= '0;
            r_a_rdy   <= 1'b0;
            r_b_rdy   <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_lcount  <= w_lcount_n;
            r_sel_b   <= w_sel_b_n;
            r_be      <= w_be_n;
            r_wdata   <= w_wdata_n;
            r_cs_b    <= w_cs_b_n;
            r_oe_b    <= w_oe_b_n;
            r_we_b    <= w_we_b_n;
            r_dout_oe <= w_dout_oe_n;
            r_addr    <= w_addr_n;
            r_dout    <= w_dout_n;
            r_a_rdata <= w_a_rdata_n;
            r_b_rdata <= w_b_rdata_n;
            r_a_rdy   <= w_a_rdy_n;
            r_b_rdy   <= w_b_rdy_n;
        end
    end

    assign o_ram_cs_b    = r_cs_b;
    assign o_ram_oe_b    = r_oe_b;
    assign o_ram_we_b    = r_we_b;
    assign o_ram_dout_oe = r_dout_oe;
    assign o_ram_addr    = r_addr;
    assign o_ram_dout    = r_dout;
    assign o_a_rdata     = r_a_rdata;
    assign o_b_rdata     = r_b_rdata;
    assign o_a_rdy       = r_a_rdy;
    assign o_b_rdy       = r_b_rdy;

endmodule
